axi_burst_master: RTL
=====================

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 SHALL have parameter en_4kb_check, default "true"; when "true", commands crossing a 4KB boundary are rejected.
REQ-002 SHALL have parameter en_expt_tip, default "false"; when "false", wt_last_mismatch_err is tied to 0.
REQ-003 SHALL use one clock and a synchronous active-high reset: clk input 1, the only clock; rst input 1, synchronous reset, active-high.
REQ-004 Command AXIS inputs: s_axis_cmd_data in 32, start byte address (word-aligned); s_axis_cmd_user in 9, {is_read(1), len-1(8)}; s_axis_cmd_valid in 1.
REQ-005 Command AXIS output: s_axis_cmd_ready out 1.
REQ-006 Write-data AXIS: s_axis_wt_data in 32; s_axis_wt_keep in 4; s_axis_wt_last in 1; s_axis_wt_valid in 1; s_axis_wt_ready out 1.
REQ-007 Read-data AXIS: m_axis_rd_data out 32; m_axis_rd_last out 1; m_axis_rd_valid out 1; m_axis_rd_ready in 1.
REQ-008 AXI master ports:
- AR: m_axi_araddr 32, arlen 8, arsize 3, arburst 2, arvalid out, arready in.
- R: rdata 32, rresp 2, rlast, rvalid in; rready out.
- AW: awaddr 32, awlen 8, awsize 3, awburst 2, awvalid out, awready in.
- W: wdata 32, wstrb 4, wlast, wvalid out; wready in.
- B: bresp 2, bvalid in; bready out.
REQ-009 Status outputs: trans_done out 1, one-cycle pulse per completed command; trans_err out 1, valid with trans_done; cmd_4kb_err out 1, one-cycle pulse; wt_last_mismatch_err out 1, one-cycle pulse.

Function
REQ-010 SHALL issue only INCR bursts, full width: ar/awburst=2'b01, ar/awsize=3'b010, constant.
REQ-011 SHALL have one transaction outstanding; FSM states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
REQ-012 s_axis_cmd_ready SHALL be 1 only in IDLE; a command is accepted on valid&ready.
REQ-013 On accept, SHALL register the address and len into ar*/aw* and go to RD_ADDR if is_read, else WR_ADDR; the address phase starts the next cycle.
REQ-014 With en_4kb_check="true", when addr[11:0] + 4*(len-1+1) > 4096: consume the command, pulse cmd_4kb_err, stay IDLE, no AXI activity, no trans_done.
REQ-015 In RD_ADDR/WR_ADDR, ar/awvalid SHALL be a registered 1 and held with stable payload until ar/awready; after that handshake, go to RD_DATA/WR_DATA.
REQ-016 In RD_DATA, read data SHALL pass through combinationally: m_axis_rd_data=rdata, m_axis_rd_valid=rvalid, m_axi_rready=m_axis_rd_ready, m_axis_rd_last=rlast.
REQ-017 RD_DATA SHALL accumulate any rresp!=2'b00 into a sticky error bit; on the rlast handshake, pulse trans_done with trans_err=sticky and return to IDLE.
REQ-018 In WR_DATA, write data SHALL pass through: wdata=s_axis_wt_data, wstrb=s_axis_wt_keep, wvalid=s_axis_wt_valid, s_axis_wt_ready=wready.
REQ-019 WR_DATA SHALL count beats (8-bit counter); wlast=1 when count==len-1, independent of s_axis_wt_last.
REQ-020 On a W beat where s_axis_wt_last!=wlast, pulse wt_last_mismatch_err (en_expt_tip="true") and continue per the counter.
REQ-021 After the wlast handshake, go to WR_RESP; bready=1 only in WR_RESP; on bvalid, pulse trans_done with trans_err=(bresp!=2'b00) and return to IDLE.
REQ-022 Outside the matching data state, all pass-through valid/ready outputs SHALL be 0.
REQ-023 len-1=0 (single beat) SHALL work: rlast/wlast on beat 0.
REQ-024 Back-to-back: the next command SHALL be accepted in the cycle after trans_done.

Reset
REQ-025 During rst: state=IDLE, arvalid=awvalid=0, addr/len registers=0, beat counter=0, sticky error=0, all pulses=0; s_axis_cmd_ready=0 while rst=1.
REQ-026 rst mid-transaction SHALL abort immediately with no trans_done; responsibility for the AXI slave state lies with the system reset.

Structure
REQ-027 Shared package SHALL hold the FSM state encoding, AXI_BURST_INCR, AXI_SIZE_4B, AXI_RESP_OKAY, and the cmd_user field positions.
REQ-028 SHALL be a single flat module with no sub-module; optional register slices are external.

Verification
REQ-029 Read cmd addr=0x100, len-1=3; slave returns 0xA0..0xA3 OKAY -> araddr=0x100, arlen=3, 4 beats out, rd_last on the 4th, trans_done=1, trans_err=0.
REQ-030 Write cmd addr=0x200, len-1=7, keep=4'hF, bresp=OKAY with wready toggling 1/0 -> 8 W beats, wlast only on the 8th, bready only in WR_RESP, trans_done, trans_err=0.
REQ-031 Cmd addr=0xFF8, len-1=3 (crosses 4KB) -> cmd_4kb_err pulse, no arvalid, the next valid cmd is accepted.
REQ-032 Read with rresp=2'b10 on beat 1 of 2 -> trans_done with trans_err=1.
REQ-033 Write len-1=0 with s_axis_wt_last=0 -> wlast=1 on beat 0 and wt_last_mismatch_err pulse.
REQ-034 rst asserted during RD_DATA beat 2 -> next cycle state=IDLE, all valids 0, no trans_done.

Source files
------------

// File: rtl/axi_burst_master_pkg.sv
// rtl/axi_burst_master_pkg.sv - shared encodings and helpers for the AXI burst master
package axi_burst_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_ADDR = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_WR_RESP = 3'd5
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // cmd_user layout: {is_read, len-1}
    localparam int CMD_USER_W      = 9;
    localparam int CMD_IS_READ_BIT = 8;
    localparam int CMD_LEN_MSB     = 7;
    localparam int CMD_LEN_LSB     = 0;

    // A burst of (len_m1+1) words starting at addr must end at or before the 4KB page end.
    function automatic logic crosses_4kb(input logic [31:0] addr, input logic [7:0] len_m1);
        logic [12:0] end_off;
        end_off = {1'b0, addr[11:0]} + {3'b000, len_m1, 2'b00} + 13'd4;
        return end_off > 13'd4096;
    endfunction

endpackage

// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - single-outstanding AXI4 INCR burst master driven by AXIS commands
module axi_burst_master
    import axi_burst_master_pkg::*;
#(
    parameter string en_4kb_check = "true",
    parameter string en_expt_tip  = "false"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           s_axis_cmd_data,
    input  logic [CMD_USER_W-1:0] s_axis_cmd_user,
    input  logic                  s_axis_cmd_valid,
    output logic                  s_axis_cmd_ready,
    input  logic [31:0]           s_axis_wt_data,
    input  logic [3:0]            s_axis_wt_keep,
    input  logic                  s_axis_wt_last,
    input  logic                  s_axis_wt_valid,
    output logic                  s_axis_wt_ready,
    output logic [31:0]           m_axis_rd_data,
    output logic                  m_axis_rd_last,
    output logic                  m_axis_rd_valid,
    input  logic                  m_axis_rd_ready,
    output logic [31:0]           m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [31:0]           m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic                  trans_done,
    output logic                  trans_err,
    output logic                  cmd_4kb_err,
    output logic                  wt_last_mismatch_err
);

    localparam bit CHK_4KB = (en_4kb_check == "true");
    localparam bit TIP_EN  = (en_expt_tip == "true");

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [7:0]  beat_cnt;
    logic        sticky_err;
    logic        arvalid_q;
    logic        awvalid_q;

    logic        rd_phase;
    logic        wr_phase;
    logic        resp_phase;
    logic        cmd_hs;
    logic        cmd_is_read;
    logic [7:0]  cmd_len;
    logic        cmd_bad;
    logic        cmd_go;
    logic        ar_hs;
    logic        aw_hs;
    logic        r_hs;
    logic        w_hs;
    logic        b_hs;
    logic        wlast_i;

    // Phase qualifiers drop to 0 during reset so nothing leaks out in the reset cycle.
    assign rd_phase    = (state == ST_RD_DATA) && !rst;
    assign wr_phase    = (state == ST_WR_DATA) && !rst;
    assign resp_phase  = (state == ST_WR_RESP) && !rst;

    assign cmd_is_read = s_axis_cmd_user[CMD_IS_READ_BIT];
    assign cmd_len     = s_axis_cmd_user[CMD_LEN_MSB:CMD_LEN_LSB];
    assign cmd_hs      = s_axis_cmd_valid && (state == ST_IDLE) && !rst;
    assign cmd_bad     = CHK_4KB && crosses_4kb(s_axis_cmd_data, cmd_len);
    assign cmd_go      = cmd_hs && !cmd_bad;

    assign ar_hs       = arvalid_q && m_axi_arready;
    assign aw_hs       = awvalid_q && m_axi_awready;
    assign r_hs        = rd_phase && m_axi_rvalid && m_axis_rd_ready;
    assign w_hs        = wr_phase && s_axis_wt_valid && m_axi_wready;
    assign b_hs        = resp_phase && m_axi_bvalid;
    assign wlast_i     = wr_phase && (beat_cnt == len_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: one transaction at a time, address phase then data then (writes) response
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (cmd_go) state_nxt = cmd_is_read ? ST_RD_ADDR : ST_WR_ADDR;
            ST_RD_ADDR: if (ar_hs) state_nxt = ST_RD_DATA;
            ST_RD_DATA: if (r_hs && m_axi_rlast) state_nxt = ST_IDLE;
            ST_WR_ADDR: if (aw_hs) state_nxt = ST_WR_DATA;
            ST_WR_DATA: if (w_hs && wlast_i) state_nxt = ST_WR_RESP;
            ST_WR_RESP: if (b_hs) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: pass-through data paths gated by phase, plus single-cycle status pulses
    always_comb begin
        s_axis_cmd_ready     = (state == ST_IDLE) && !rst;
        m_axis_rd_data       = m_axi_rdata;
        m_axis_rd_valid      = rd_phase && m_axi_rvalid;
        m_axis_rd_last       = rd_phase && m_axi_rlast;
        m_axi_rready         = rd_phase && m_axis_rd_ready;
        m_axi_wdata          = s_axis_wt_data;
        m_axi_wstrb          = s_axis_wt_keep;
        m_axi_wvalid         = wr_phase && s_axis_wt_valid;
        s_axis_wt_ready      = wr_phase && m_axi_wready;
        m_axi_wlast          = wlast_i;
        m_axi_bready         = resp_phase;
        trans_done           = (r_hs && m_axi_rlast) || b_hs;
        trans_err            = 1'b0;
        if (r_hs && m_axi_rlast) trans_err = sticky_err || (m_axi_rresp != AXI_RESP_OKAY);
        else if (b_hs)           trans_err = (m_axi_bresp != AXI_RESP_OKAY);
        cmd_4kb_err          = cmd_hs && cmd_bad;
        wt_last_mismatch_err = TIP_EN && w_hs && (s_axis_wt_last != wlast_i);
    end

    // Command capture, address-valid holding, beat counting and read error accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt   <= '0;
            sticky_err <= 1'b0;
            arvalid_q  <= 1'b0;
            awvalid_q  <= 1'b0;
        end else begin
            if (cmd_go) begin
                addr_q     <= s_axis_cmd_data;
                len_q      <= cmd_len;
                beat_cnt   <= '0;
                sticky_err <= 1'b0;
                arvalid_q  <= cmd_is_read;
                awvalid_q  <= !cmd_is_read;
            end
            if (ar_hs) arvalid_q <= 1'b0;
            if (aw_hs) awvalid_q <= 1'b0;
            if (r_hs && (m_axi_rresp != AXI_RESP_OKAY)) sticky_err <= 1'b1;
            if (w_hs) beat_cnt <= beat_cnt + 8'd1;
        end
    end

    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = AXI_SIZE_4B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = AXI_SIZE_4B;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awvalid = awvalid_q;

endmodule
